// File: rtl/onehot_strobe_decoder_pkg.sv
// Shared widths, state encoding and the 3-to-8 one-hot reference function
// for the one-hot strobe decoder (optional input buffer: ONEHOT_DEC_BUF_EN).
package onehot_dec_pkg;

    localparam int CODE_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dec_state_t;

    function automatic logic [DATA_W-1:0] onehot3to8(input logic [CODE_W-1:0] code);
        return DATA_W'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_strobe_decoder_if.sv
// Code/strobe bus of the one-hot strobe decoder: the master drives codes,
// the slave (decoder) returns ready and the held one-hot strobe.
interface onehot_strobe_decoder_if;
    import onehot_dec_pkg::*;

    logic [CODE_W-1:0] code_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output code_i, valid_i,
        input  ready_o, data_o, busy_o, done_o
    );

    modport slave (
        input  code_i, valid_i,
        output ready_o, data_o, busy_o, done_o
    );

endinterface

// File: rtl/onehot_strobe_decoder_buf.sv
// Single-entry code buffer used by the decoder when ONEHOT_DEC_BUF_EN is
// defined; ready_o is registered and equals ~full for the next cycle.
module onehot_dec_buf
    import onehot_dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [CODE_W-1:0] code_i,
    output logic              full_o,
    output logic [CODE_W-1:0] code_o,
    output logic              ready_o
);

    logic              full_q,  full_d;
    logic [CODE_W-1:0] code_q,  code_d;
    logic              ready_q, ready_d;

    // A push in the same cycle as a pop refills the entry.
    always_comb begin
        full_d  = push_i | (full_q & ~pop_i);
        code_d  = push_i ? code_i : code_q;
        ready_d = ~full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: code_q is only consumed while full_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        code_q <= code_d;
    end

    assign full_o  = full_q;
    assign code_o  = code_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Accepts 3-bit codes and holds the matching one-hot strobe for HOLD_CYCLES
// cycles. Define ONEHOT_DEC_BUF_EN to add a one-entry input buffer.
module onehot_strobe_decoder
    import onehot_dec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    onehot_strobe_decoder_if.slave  bus
);

    localparam int              CNT_W    = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    dec_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;

    logic              core_free;
    logic              accept;
    logic              load_en;
    logic [CODE_W-1:0] load_code;

    // The core can take a new code when idle or in the last hold cycle.
    assign core_free = (state_q == IDLE) || (cnt_q == '0);

`ifdef ONEHOT_DEC_BUF_EN
    logic              buf_full;
    logic              buf_ready;
    logic              buf_push;
    logic              buf_pop;
    logic [CODE_W-1:0] buf_code;

    assign accept    = bus.valid_i & buf_ready;
    assign buf_pop   = core_free & buf_full;
    assign load_en   = buf_pop | (core_free & accept);
    assign load_code = buf_full ? buf_code : bus.code_i;
    assign buf_push  = accept & ~(core_free & ~buf_full);
    assign bus.ready_o = buf_ready;

    onehot_dec_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .code_i  (bus.code_i),
        .full_o  (buf_full),
        .code_o  (buf_code),
        .ready_o (buf_ready)
    );
`else
    assign accept      = bus.valid_i & core_free;
    assign load_en     = accept;
    assign load_code   = bus.code_i;
    assign bus.ready_o = core_free;
`endif

    // NOTE: every variable gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (load_en) begin
            state_d = HOLD;
            data_d  = onehot3to8(load_code);
            cnt_d   = CNT_LOAD;
        end else if (state_q == HOLD) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                data_d  = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign bus.data_o = data_q;
    assign bus.busy_o = (state_q == HOLD);
    assign bus.done_o = (state_q == HOLD) && (cnt_q == '0);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench for onehot_strobe_decoder: one instance with HOLD_CYCLES=4,
// one with HOLD_CYCLES=1; buffer checks run when ONEHOT_DEC_BUF_EN is set.
module tb_onehot_strobe_decoder;

`ifdef ONEHOT_DEC_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   n_done;

    logic [7:0] exp_oh [8];

    onehot_strobe_decoder_if bus4 ();
    onehot_strobe_decoder_if bus1 ();

    onehot_strobe_decoder #(.HOLD_CYCLES(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    onehot_strobe_decoder #(.HOLD_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] encode8to3(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 0; b < 8; b++) if (oh[b]) r = 3'(b);
        return r;
    endfunction

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;
        exp_oh = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset held for two cycles with valid asserted.
        rst = 1'b1;
        bus4.valid_i = 1'b1; bus4.code_i = 3'd3;
        bus1.valid_i = 1'b1; bus1.code_i = 3'd3;
        step();
        step();
        check("rst_data",  bus4.data_o, 8'h00);
        check("rst_busy",  8'(bus4.busy_o), 8'h00);
        check("rst_done",  8'(bus4.done_o), 8'h00);
        rst = 1'b0;
        bus4.valid_i = 1'b0;
        bus1.valid_i = 1'b0;
        step();
        check("post_rst_ready4", 8'(bus4.ready_o), 8'h01);
        check("post_rst_ready1", 8'(bus1.ready_o), 8'h01);
        check("post_rst_data4",  bus4.data_o, 8'h00);
        check("post_rst_data1",  bus1.data_o, 8'h00);

        // Single code 5, hold 4.
        bus4.code_i = 3'd5; bus4.valid_i = 1'b1;
        step();
        bus4.valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("single_data",  bus4.data_o, 8'h20);
            check("single_busy",  8'(bus4.busy_o), 8'h01);
            check("single_done",  8'(bus4.done_o), 8'(i == 4));
            check("single_ready", 8'(bus4.ready_o), 8'(BUF_EN || (i == 4)));
            step();
        end
        check("single_end_data", bus4.data_o, 8'h00);
        check("single_end_busy", 8'(bus4.busy_o), 8'h00);
        check("single_end_done", 8'(bus4.done_o), 8'h00);

        // Back-to-back codes 0 then 7 with valid held high.
        bus4.code_i = 3'd0; bus4.valid_i = 1'b1;
        step();
        bus4.code_i = 3'd7;
        n_done = 0;
        for (int i = 1; i <= 8; i++) begin
            check("b2b_data", bus4.data_o, (i <= 4) ? 8'h01 : 8'h80);
            if (bus4.done_o) n_done++;
            if (i == 5) bus4.valid_i = 1'b0;
            step();
        end
        check("b2b_end_data", bus4.data_o, 8'h00);
        check("b2b_done_cnt", 8'(n_done), 8'd2);

        // HOLD_CYCLES=1: every code on consecutive cycles.
        bus1.code_i = 3'd0; bus1.valid_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("h1_data",   bus1.data_o, exp_oh[k]);
            check("h1_encode", 8'(encode8to3(bus1.data_o)), 8'(k));
            check("h1_ready",  8'(bus1.ready_o), 8'h01);
            check("h1_done",   8'(bus1.done_o), 8'h01);
            check("h1_busy",   8'(bus1.busy_o), 8'h01);
            if (k < 7) bus1.code_i = 3'(k + 1);
            else       bus1.valid_i = 1'b0;
        end
        step();
        check("h1_end_data", bus1.data_o, 8'h00);
        check("h1_end_done", 8'(bus1.done_o), 8'h00);

        // Reset during the second hold cycle of code 2.
        bus4.code_i = 3'd2; bus4.valid_i = 1'b1;
        step();
        bus4.valid_i = 1'b0;
        check("mid_h1_data", bus4.data_o, 8'h04);
        step();
        check("mid_h2_data", bus4.data_o, 8'h04);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_data", bus4.data_o, 8'h00);
        check("mid_rst_busy", 8'(bus4.busy_o), 8'h00);
        check("mid_rst_done", 8'(bus4.done_o), 8'h00);
        step();
        check("mid_idle_data", bus4.data_o, 8'h00);
        check("mid_idle_done", 8'(bus4.done_o), 8'h00);
        bus4.code_i = 3'd6; bus4.valid_i = 1'b1;
        step();
        bus4.valid_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("mid_next_data", bus4.data_o, 8'h40);
            check("mid_next_done", 8'(bus4.done_o), 8'(i == 4));
            step();
        end
        check("mid_next_end", bus4.data_o, 8'h00);

`ifdef ONEHOT_DEC_BUF_EN
        // Code 4 arrives on the second hold cycle of code 1 and is buffered.
        bus4.code_i = 3'd1; bus4.valid_i = 1'b1;
        step();
        bus4.valid_i = 1'b0;
        check("buf_h1_data", bus4.data_o, 8'h02);
        step();
        check("buf_h2_ready", 8'(bus4.ready_o), 8'h01);
        bus4.code_i = 3'd4; bus4.valid_i = 1'b1;
        step();
        bus4.valid_i = 1'b0;
        check("buf_h3_data",  bus4.data_o, 8'h02);
        check("buf_h3_ready", 8'(bus4.ready_o), 8'h00);
        step();
        check("buf_h4_data",  bus4.data_o, 8'h02);
        check("buf_h4_ready", 8'(bus4.ready_o), 8'h00);
        check("buf_h4_done",  8'(bus4.done_o), 8'h01);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("buf_next_data",  bus4.data_o, 8'h10);
            check("buf_next_ready", 8'(bus4.ready_o), 8'h01);
            check("buf_next_done",  8'(bus4.done_o), 8'(i == 4));
        end
        step();
        check("buf_end_data", bus4.data_o, 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
